// File: rtl/de2i_input_pkg.sv
// de2i_input_pkg
//   Shared constants for the DE2i-150 front-panel input conditioner:
//   default sizes, the 50 MHz debounce length, the filter counter width
//   helper, and the switches_word field layout used by the host driver.
package de2i_input_pkg;

  localparam int unsigned N_BTN_DEFAULT         = 4;
  localparam int unsigned N_SW_DEFAULT          = 18;
  localparam int unsigned CNT_W_DEFAULT         = 3;
  localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 50000;  // 1 ms at 50 MHz

  // switches_word layout (default build): [17:0] switches,
  // [29:18] press counters with button 0 lowest, [31:30] zero.
  localparam int unsigned STATUS_W      = 32;
  localparam int unsigned SW_FIELD_LSB  = 0;
  localparam int unsigned CNT_FIELD_LSB = N_SW_DEFAULT;

  // Released level of an active-low pushbutton.
  localparam logic BTN_RELEASED = 1'b1;
  localparam logic SW_OFF       = 1'b0;

  // Width of the stable-count filter counter; never narrower than 1 bit.
  function automatic int unsigned dbc_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  // LSB of press counter idx inside switches_word.
  function automatic int unsigned press_cnt_lsb(input int unsigned n_sw,
                                                input int unsigned cnt_w,
                                                input int unsigned idx);
    return n_sw + idx * cnt_w;
  endfunction

endpackage

// File: rtl/de2i_input_debounce_bit.sv
// debounce_bit
//   Single-bit conditioner: 2-flop synchronizer followed by a stable-count
//   filter. A new level is accepted only after DEBOUNCE_CYCLES consecutive
//   samples that differ from the current stable level.
// Ports:
//   clk        - core clock
//   reset_n    - synchronous active-low reset
//   raw        - asynchronous input bit
//   level      - registered debounced level
//   level_next - value level takes on the next clock edge (for edge detect)
module debounce_bit
  import de2i_input_pkg::*;
#(
  parameter logic        RESET_LEVEL     = 1'b0,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic level_next
);

  localparam int unsigned     CW       = dbc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;
  logic          accept;

  // Plain flop-to-flop synchronizer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= RESET_LEVEL;
      sync_q2 <= RESET_LEVEL;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign accept     = (sync_q2 != level) && (cnt == CNT_LAST);
  assign level_next = accept ? sync_q2 : level;

  // Any sample equal to the stable level restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level <= RESET_LEVEL;
      cnt   <= '0;
    end else begin
      level <= level_next;
      if ((sync_q2 == level) || (cnt == CNT_LAST)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/de2i_input_debounce.sv
// de2i_input_debounce
//   Conditions DE2i-150 KEY/SW inputs for the PCIe core PIOs: every bit is
//   synchronized and debounced; each button also keeps a wrapping press
//   counter that is packed above the switches in switches_word.
// Ports:
//   clk_clk       - core clock (50 MHz)
//   reset_reset_n - synchronous active-low reset
//   key_raw       - raw pushbuttons, active-low
//   sw_raw        - raw slide switches
//   buttons_db    - debounced pushbuttons, active-low
//   switches_word - {0, press counters, debounced switches}
//   press_pulse   - one-cycle strobe per accepted press
module de2i_input_debounce
  import de2i_input_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEFAULT,
  parameter int unsigned N_SW            = N_SW_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [N_BTN-1:0]    key_raw,
  input  logic [N_SW-1:0]     sw_raw,
  output logic [N_BTN-1:0]    buttons_db,
  output logic [STATUS_W-1:0] switches_word,
  output logic [N_BTN-1:0]    press_pulse
);

  logic [N_BTN-1:0] btn_next;
  logic [N_BTN-1:0] btn_fall;
  logic [N_SW-1:0]  sw_db;
  logic [N_SW-1:0]  unused_sw_next;
  logic [CNT_W-1:0] press_cnt [N_BTN];

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    debounce_bit #(
      .RESET_LEVEL     (BTN_RELEASED),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk        (clk_clk),
      .reset_n    (reset_reset_n),
      .raw        (key_raw[gi]),
      .level      (buttons_db[gi]),
      .level_next (btn_next[gi])
    );
  end

  for (genvar gs = 0; gs < N_SW; gs++) begin : g_sw
    debounce_bit #(
      .RESET_LEVEL     (SW_OFF),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk        (clk_clk),
      .reset_n    (reset_reset_n),
      .raw        (sw_raw[gs]),
      .level      (sw_db[gs]),
      .level_next (unused_sw_next[gs])
    );
  end

  // Press = stable level about to go 1->0; looking at the next value lets
  // the pulse and the counter update land on the same edge as buttons_db.
  assign btn_fall = buttons_db & ~btn_next;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      press_pulse <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        press_cnt[i] <= '0;
      end
    end else begin
      press_pulse <= btn_fall;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (btn_fall[i]) begin
          press_cnt[i] <= press_cnt[i] + CNT_W'(1);  // wraps by design
        end
      end
    end
  end

  always_comb begin
    switches_word = '0;
    switches_word[SW_FIELD_LSB +: N_SW] = sw_db;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      switches_word[press_cnt_lsb(N_SW, CNT_W, i) +: CNT_W] = press_cnt[i];
    end
  end

endmodule

// File: tb/tb_de2i_input_debounce.sv
// Self-checking bench for de2i_input_debounce with DEBOUNCE_CYCLES = 4.
module tb_de2i_input_debounce;

  localparam int unsigned DC  = 4;
  localparam int unsigned LAT = 2 + DC;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [3:0]  key_raw;
  logic [17:0] sw_raw;
  logic [3:0]  buttons_db;
  logic [31:0] switches_word;
  logic [3:0]  press_pulse;

  de2i_input_debounce #(
    .N_BTN           (4),
    .N_SW            (18),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (3)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .key_raw       (key_raw),
    .sw_raw        (sw_raw),
    .buttons_db    (buttons_db),
    .switches_word (switches_word),
    .press_pulse   (press_pulse)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    string       tag;
    int unsigned due;
    logic [3:0]  btn_mask;
    logic [3:0]  btn;
    logic [31:0] word_mask;
    logic [31:0] word;
    logic [3:0]  pulse_mask;
    logic [3:0]  pulse;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_total = 0;
  int unsigned pulse_seen [4] = '{default: 0};
  int unsigned base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_at(input string tag, input int unsigned due,
                           input logic [3:0] bm, input logic [3:0] b,
                           input logic [31:0] wm, input logic [31:0] w,
                           input logic [3:0] pm, input logic [3:0] p);
    exp_t e;
    e.tag = tag; e.due = due;
    e.btn_mask = bm; e.btn = b;
    e.word_mask = wm; e.word = w;
    e.pulse_mask = pm; e.pulse = p;
    sbq.push_back(e);
  endtask

  // Inputs change 2 time units after an edge, after the monitor has sampled.
  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk_clk);
      #2;
    end
  endtask

  // Monitor: samples 1 time unit after each edge, pops due scoreboard entries.
  always @(posedge clk_clk) begin
    #1;
    cyc++;
    for (int b = 0; b < 4; b++) begin
      if (press_pulse[b] === 1'b1) pulse_seen[b]++;
    end
    for (int k = int'(sbq.size()) - 1; k >= 0; k--) begin
      if (sbq[k].due <= cyc) begin
        mon_e = sbq[k];
        if (mon_e.due < cyc) chk({mon_e.tag, "_late"}, 32'(cyc), 32'(mon_e.due));
        chk({mon_e.tag, "_btn"}, 32'(buttons_db & mon_e.btn_mask),
            32'(mon_e.btn & mon_e.btn_mask));
        chk({mon_e.tag, "_word"}, switches_word & mon_e.word_mask,
            mon_e.word & mon_e.word_mask);
        chk({mon_e.tag, "_pulse"}, 32'(press_pulse & mon_e.pulse_mask),
            32'(mon_e.pulse & mon_e.pulse_mask));
        sbq.delete(k);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with random raw inputs.
    reset_reset_n = 1'b0;
    key_raw = 4'($urandom);
    sw_raw  = 18'($urandom);
    repeat (3) begin
      tick(1);
      key_raw = 4'($urandom);
      sw_raw  = 18'($urandom);
    end
    chk("rst_btn", 32'(buttons_db), 32'hF);
    chk("rst_word", switches_word, 32'h0);
    chk("rst_pulse", 32'(press_pulse), 32'h0);
    key_raw = 4'hF;
    sw_raw  = '0;
    tick(1);
    reset_reset_n = 1'b1;
    tick(LAT + 4);
    chk("idle_btn", 32'(buttons_db), 32'hF);
    chk("idle_word", switches_word, 32'h0);

    // Clean switch edge.
    sw_raw[5] = 1'b1;
    expect_at("sw5_early", cyc + LAT - 1, 4'hF, 4'hF, '1, 32'h0, 4'hF, 4'h0);
    expect_at("sw5", cyc + LAT, 4'hF, 4'hF, '1, 32'h20, 4'hF, 4'h0);
    tick(LAT + 4);

    // Bounce on key 2: 3-cycle levels never reach the output.
    base = pulse_seen[2];
    for (int p = 0; p < 5; p++) begin
      key_raw[2] = 1'b0; tick(3);
      key_raw[2] = 1'b1; tick(3);
    end
    chk("bounce_none", 32'(pulse_seen[2] - base), 32'd0);
    chk("bounce_btn", 32'(buttons_db), 32'hF);
    key_raw[2] = 1'b0;
    expect_at("bounce_early", cyc + LAT - 1, 4'h4, 4'h4, 32'h0, 32'h0, 4'hF, 4'h0);
    expect_at("bounce_press", cyc + LAT, 4'h4, 4'h0, 32'h0700_0000, 32'h0100_0000, 4'hF, 4'h4);
    expect_at("bounce_once", cyc + LAT + 1, 4'h0, 4'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    tick(LAT + 4);
    chk("bounce_pulses", 32'(pulse_seen[2] - base), 32'd1);
    key_raw[2] = 1'b1;
    tick(LAT + 4);
    chk("release_nopulse", 32'(pulse_seen[2] - base), 32'd1);

    // Nine presses on key 0: counter wraps 7->0 and reads 1.
    base = pulse_seen[0];
    for (int p = 0; p < 9; p++) begin
      key_raw[0] = 1'b0; tick(LAT + 2);
      key_raw[0] = 1'b1; tick(LAT + 2);
      if (p == 7) chk("wrap_zero", 32'(switches_word[20:18]), 32'd0);
    end
    chk("wrap_pulses", 32'(pulse_seen[0] - base), 32'd9);
    chk("wrap_cnt0", 32'(switches_word[20:18]), 32'd1);

    // Fresh counters, then all keys pressed together.
    sw_raw = '0;
    reset_reset_n = 1'b0;
    tick(2);
    reset_reset_n = 1'b1;
    tick(2);
    chk("rst2_word", switches_word, 32'h0);
    key_raw = 4'h0;
    expect_at("simul_early", cyc + LAT - 1, 4'hF, 4'hF, '1, 32'h0, 4'hF, 4'h0);
    expect_at("simul", cyc + LAT, 4'hF, 4'h0, 32'h3FFC_0000, 32'h0924_0000, 4'hF, 4'hF);
    expect_at("simul_once", cyc + LAT + 1, 4'hF, 4'h0, '1, 32'h0924_0000, 4'hF, 4'h0);
    tick(LAT + 4);
    key_raw = 4'hF;
    tick(LAT + 4);

    // Reset mid-count with key 1 held through it.
    base = pulse_seen[1];
    key_raw[1] = 1'b0;
    tick(2);
    reset_reset_n = 1'b0;
    tick(1);
    reset_reset_n = 1'b1;
    chk("mid_rst_btn", 32'(buttons_db), 32'hF);
    chk("mid_rst_word", switches_word, 32'h0);
    chk("mid_rst_nopulse", 32'(pulse_seen[1] - base), 32'd0);
    for (int d = 1; d < int'(LAT); d++) begin
      expect_at("mid_hold", cyc + d, 4'h2, 4'h2, 32'h0, 32'h0, 4'hF, 4'h0);
    end
    expect_at("mid_press", cyc + LAT, 4'h2, 4'h0, 32'h00E0_0000, 32'h0020_0000, 4'hF, 4'h2);
    expect_at("mid_once", cyc + LAT + 1, 4'h0, 4'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    tick(LAT + 4);
    chk("mid_pulses", 32'(pulse_seen[1] - base), 32'd1);
    key_raw[1] = 1'b1;
    tick(LAT + 4);

    // Drain any outstanding expectations within a bounded wait.
    for (int g = 0; g < 50 && sbq.size() != 0; g++) tick(1);
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
